// File: rtl/warmboot_ctrl_if.sv
// CPU-side register bus for the warm-boot sequencer.
// The I/O decoder drives the write strobe, the register select and the write data.
// The sequencer returns the read data.
interface warmboot_ctrl_if;
    logic       WR_STB;
    logic       ADDR;
    logic [7:0] WDATA;
    logic [7:0] RDATA;

    // Bus master side (the I/O decoder or the CPU model).
    modport master (
        output WR_STB,
        output ADDR,
        output WDATA,
        input  RDATA
    );

    // Register block side (the warm-boot sequencer).
    modport slave (
        input  WR_STB,
        input  ADDR,
        input  WDATA,
        output RDATA
    );
endinterface

// File: rtl/warmboot_ctrl.sv
// Warm-boot sequencer for the iCE40 SB_WARMBOOT primitive.
// Z80 software unlocks the sequencer with a two-byte key, then picks one of
// four configuration images and fires a GO. The chosen image select is held
// stable on S1/S0 for DELAY_CYCLES before BOOT is raised. BOOT then stays
// high until reset.
// A stray write, a wrong key, or a missing GO inside the arming window aborts
// the sequence and latches the sticky ERR flag.
module warmboot_ctrl #(
    parameter logic [7:0] KEY1         = 8'hA5,
    parameter logic [7:0] KEY2         = 8'h5A,
    parameter int         ARM_TIMEOUT  = 255,
    parameter int         DELAY_CYCLES = 1024,
    parameter int         CW           = 16
) (
    input  logic           CLK1,
    input  logic           RST_N,
    warmboot_ctrl_if.slave bus,
    output logic           S0,
    output logic           S1,
    output logic           BOOT
);

    // Sequencer states; encoding kept as plain constants for legacy tools.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_KEY1  = 3'd1;
    localparam logic [2:0] ST_ARMED = 3'd2;
    localparam logic [2:0] ST_SETUP = 3'd3;
    localparam logic [2:0] ST_BOOT  = 3'd4;

    // Countdown reload values, sized to the shared counter.
    localparam logic [CW-1:0] ARM_LOAD   = CW'(ARM_TIMEOUT);
    localparam logic [CW-1:0] SETUP_LOAD = CW'(DELAY_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [1:0]    img_q,   img_d;
    logic          err_q,   err_d;
    logic          boot_q,  boot_d;

    logic          key_wr_s;
    logic          ctrl_wr_s;
    logic          go_s;
    logic          clr_s;
    logic          busy_s;
    logic          err_set_s;
    logic          clr_ok_s;
    logic [7:0]    status_s;

    // Decode the incoming strobe into key and control writes.
    always_comb begin
        key_wr_s  = bus.WR_STB & bus.ADDR;
        ctrl_wr_s = bus.WR_STB & ~bus.ADDR;
        go_s      = bus.WDATA[7];
        clr_s     = bus.WDATA[6];
        busy_s    = (state_q == ST_SETUP) || (state_q == ST_BOOT);
    end

    // Next-state, countdown, image latch and error-event logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        img_d     = img_q;
        err_set_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (key_wr_s) begin
                    if (bus.WDATA == KEY1) begin
                        state_d = ST_KEY1;
                    end else begin
                        err_set_s = 1'b1;
                    end
                end else if (ctrl_wr_s && go_s) begin
                    err_set_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_KEY1: begin
                if (key_wr_s) begin
                    if (bus.WDATA == KEY2) begin
                        state_d = ST_ARMED;
                        cnt_d   = ARM_LOAD;
                    end else begin
                        state_d   = ST_IDLE;
                        err_set_s = 1'b1;
                    end
                end else if (ctrl_wr_s) begin
                    // Any control write breaks the unlock sequence.
                    // A GO here is also flagged as an error.
                    state_d   = ST_IDLE;
                    err_set_s = go_s;
                end else begin
                    state_d = ST_KEY1;
                end
            end
            ST_ARMED: begin
                if (ctrl_wr_s && go_s) begin
                    img_d   = bus.WDATA[1:0];
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LOAD;
                end else if (ctrl_wr_s) begin
                    state_d = ST_IDLE;
                end else if (key_wr_s) begin
                    state_d   = ST_IDLE;
                    err_set_s = 1'b1;
                end else if (cnt_q == CNT_ZERO) begin
                    state_d   = ST_IDLE;
                    err_set_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_SETUP: begin
                // Image select is frozen; writes have no effect here.
                if (cnt_q == CNT_ZERO) begin
                    state_d = ST_BOOT;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            ST_BOOT: begin
                state_d = ST_BOOT;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Sticky error flag. A set event in the same cycle beats a clear request.
    always_comb begin
        clr_ok_s = ctrl_wr_s & clr_s & ~busy_s;
        if (err_set_s) begin
            err_d = 1'b1;
        end else if (clr_ok_s) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
        boot_d = (state_d == ST_BOOT);
    end

    // State, counter, image, error and BOOT registers.
    always_ff @(posedge CLK1 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= CNT_ZERO;
            img_q   <= 2'b00;
            err_q   <= 1'b0;
            boot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            img_q   <= img_d;
            err_q   <= err_d;
            boot_q  <= boot_d;
        end
    end

    // Status word and read mux. The KEY register is write-only and reads as zero.
    always_comb begin
        status_s = {busy_s, err_q, (state_q == ST_ARMED), (state_q == ST_KEY1),
                    2'b00, img_q};
        if (bus.ADDR) begin
            bus.RDATA = 8'h00;
        end else begin
            bus.RDATA = status_s;
        end
    end

    // Outputs to SB_WARMBOOT come straight from flops.
    always_comb begin
        S0   = img_q[0];
        S1   = img_q[1];
        BOOT = boot_q;
    end

endmodule

// File: doc/warmboot_ctrl.md
Name: warmboot_ctrl

Overview:
- CPU-facing sequencer for the iCE40 SB_WARMBOOT primitive.
- Lets Z80 software select one of four configuration images and trigger a warm reboot.
- A two-byte unlock key and an arming timeout guard against stray I/O writes.
- Sits between the fpga20 I/O decoder, which supplies decoded write/read strobes, and the SB_WARMBOOT instance. It drives that instance's S0, S1 and BOOT pins.

Parameters:
- KEY1, 8'hA5, first unlock byte.
- KEY2, 8'h5A, second unlock byte.
- ARM_TIMEOUT, 255, cycles the ARMED state waits for a GO write before aborting.
- DELAY_CYCLES, 1024, cycles S1/S0 are held stable before BOOT rises. Must be >= 1.
- CW, 16, width of the shared countdown counter. Must hold max(ARM_TIMEOUT, DELAY_CYCLES-1).

Ports:
- CLK1  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- WR_STB  input  1  one-cycle write strobe from the I/O decoder.
- ADDR  input  1  register select: 0 = CTRL/STATUS, 1 = KEY.
- WDATA  input  8  write data.
- RDATA  output  8  read data, combinational from ADDR.
- S0  output  1  image select bit 0, to SB_WARMBOOT.
- S1  output  1  image select bit 1, to SB_WARMBOOT.
- BOOT  output  1  warmboot trigger, to SB_WARMBOOT.

Behaviour:
- Clock and reset: one clock, CLK1. Reset is asynchronous and active-low on RST_N.
- Reset values: state=IDLE, cnt=0, IMG=2'b00, ERR=0. Therefore S0=0, S1=0, BOOT=0, and the status read returns 8'h00.
- S1/S0 are always IMG[1]/IMG[0]. IMG is a register updated only on an accepted GO. BOOT is asserted exactly when state==BOOT.
- CTRL write bits: bit7 GO, bit6 CLR_ERR, bits1:0 image number. Other bits are ignored.
- Status read (ADDR=0):
  - bit7 BUSY, meaning SETUP or BOOT.
  - bit6 ERR.
  - bit5 ARMED.
  - bit4 KEY1_OK.
  - bits3:2 read 0.
  - bits1:0 IMG.
- KEY read (ADDR=1) returns 8'h00.
- CLR_ERR takes effect in any state except SETUP and BOOT. If an error event occurs in the same cycle, the set wins and ERR stays 1.
- State IDLE:
  - KEY write == KEY1 → KEY1_OK.
  - KEY write of any other value → stay IDLE, ERR=1.
  - CTRL write with GO=1 → stay IDLE, ERR=1.
- State KEY1_OK:
  - KEY write == KEY2 → ARMED, cnt=ARM_TIMEOUT.
  - Any other KEY write → IDLE, ERR=1.
  - CTRL write with GO=1 → IDLE, ERR=1.
  - CTRL write with GO=0 → IDLE, no error.
- State ARMED (each cycle, in priority order):
  1. CTRL write with GO=1 → IMG=WDATA[1:0], SETUP, cnt=DELAY_CYCLES-1.
  2. CTRL write with GO=0 → IDLE (cancel), no error.
  3. KEY write → IDLE, ERR=1.
  4. No write and cnt==0 → IDLE, ERR=1 (timeout).
  5. Otherwise cnt decrements.
  - Net effect: GO is accepted on any of the ARM_TIMEOUT+1 edges following the KEY2 edge.
- State SETUP:
  - All writes are ignored.
  - cnt==0 → BOOT; otherwise cnt decrements.
  - BOOT is high starting exactly DELAY_CYCLES rising edges after the edge that sampled the GO write.
  - S1/S0 are stable for that whole interval.
- State BOOT:
  - Terminal. BOOT stays 1 and writes are ignored until RST_N falls. In practice the FPGA reconfigures.
- Reset mid-operation (any state): immediate return to reset values. A pending boot is abandoned; BOOT never pulses.
- WR_STB held for multiple cycles: each cycle counts as a separate write. The decoder is responsible for single-cycle strobes.

Test Plan:
- Reset → BOOT=0, S1S0=00, RDATA(ADDR=0)=8'h00, RDATA(ADDR=1)=8'h00.
- Happy path: KEY A5, KEY 5A, CTRL 8'h82 → status reads 8'h82 and S1=1,S0=0 from the next cycle. BOOT rises exactly DELAY_CYCLES edges after the CTRL edge and stays high for 2000 further cycles. Later writes do not change S1/S0.
- Bad key: KEY A5, KEY 8'h00 → status 8'h40, state IDLE. CTRL 8'h40 → status 8'h00. KEY A5 then CTRL 8'hC0 in the same sequence → ERR set wins (status 8'h40).
- Timeout: KEY A5, KEY 5A, no writes for ARM_TIMEOUT+1 cycles → status 8'h40, BOOT never rises. Repeat with GO on edge ARM_TIMEOUT+1 → accepted (status 8'h80|img).
- Misuse: CTRL 8'h83 in IDLE → ERR=1, IMG unchanged (00), BOOT=0. Arm, then CTRL 8'h00 → IDLE, status 8'h00. Arm, then KEY write → ERR=1.
- Reset mid-SETUP: arm, GO img 3, assert RST_N low at DELAY_CYCLES/2 → S1S0=00, BOOT=0 immediately and for 2*DELAY_CYCLES after release.
